// File: rtl/virtual_axi_lite_stimulation.sv
// Purpose    : AXI4-Lite master that writes a short burst of Paillier-core command words
//              into a register file and, optionally, reads each word back to check it.
// Latency    : start edge seen 2 cycles after INIT_AXI_TXN rises; first AWVALID 1 cycle later;
//              each write/read costs handshake time plus 1 turnaround cycle.
// Backpressure: every valid holds (payload frozen) until its ready is sampled; one
//              transaction in flight at a time; BREADY/RREADY are single-cycle replies.
// Ports      : S_LITE_AXI_ACLK / S_LITE_AXI_ARESETN (async, active-high) clock and reset;
//              INIT_AXI_TXN start request; AW/W/B/AR/R AXI4-Lite master channels;
//              TXN_DONE one-cycle end-of-sequence pulse; ERROR sticky failure flag.
// Options    : define AXI_LITE_STIM_READBACK_EN to add the read-back phase and data compare.
module virtual_axi_lite_stimulation #(
  parameter logic [1:0]  PAILLIER_MODE              = 2'b00,
  parameter logic [31:0] C_M_START_DATA_VALUE       = 32'h8000_0000,
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h0000_0000,
  parameter int          C_M_TRANSACTIONS_NUM       = 1
) (
  input  logic        S_LITE_AXI_ACLK,
  input  logic        S_LITE_AXI_ARESETN,
  input  logic        INIT_AXI_TXN,
  // write address channel
  output logic [31:0] AWADDR,
  output logic [2:0]  AWPROT,
  output logic        AWVALID,
  input  logic        AWREADY,
  // write data channel
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  // write response channel
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  // read address channel
  output logic [31:0] ARADDR,
  output logic [2:0]  ARPROT,
  output logic        ARVALID,
  input  logic        ARREADY,
  // read data channel
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY,
  // status
  output logic        TXN_DONE,
  output logic        ERROR
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Index of the final transaction; the counter is wide enough for 16 entries.
  localparam logic [4:0] LAST_IDX = 5'(C_M_TRANSACTIONS_NUM - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q,    state_d;
  logic        init_q;      // INIT_AXI_TXN registered
  logic        init_dly_q;  // previous value of init_q, for edge detection
  logic [4:0]  idx_q,      idx_d;
  logic        error_q,    error_d;

  logic        wr_busy_q,  wr_busy_d;
  logic        awvalid_q,  awvalid_d;
  logic        wvalid_q,   wvalid_d;
  logic        bready_q,   bready_d;
  logic [31:0] awaddr_q,   awaddr_d;
  logic [31:0] wdata_q,    wdata_d;

  logic        start_edge;
  logic        b_hs;
  logic [31:0] txn_addr;
  logic [31:0] txn_data;

  assign start_edge = init_q & ~init_dly_q;
  assign b_hs       = BVALID & bready_q;

  // Register offset advances one 32-bit word per transaction.
  assign txn_addr = C_M_TARGET_SLAVE_BASE_ADDR + {25'd0, idx_q, 2'b00};

  // The low two bits of every command word carry the Paillier operation, so the
  // running count is masked there and the mode is inserted in its place.
  assign txn_data = ((C_M_START_DATA_VALUE + {27'd0, idx_q}) & 32'hFFFF_FFFC)
                  | {30'd0, PAILLIER_MODE};

`ifdef AXI_LITE_STIM_READBACK_EN
  logic        rd_busy_q,  rd_busy_d;
  logic        arvalid_q,  arvalid_d;
  logic        rready_q,   rready_d;
  logic [31:0] araddr_q,   araddr_d;
  logic [31:0] rexp_q,     rexp_d;    // value written to the address being read
  logic        r_hs;

  assign r_hs = RVALID & rready_q;
`else
  // Read channel inputs are not observed when read-back is compiled out.
  logic unused_rd_inputs;
  assign unused_rd_inputs = ^{ARREADY, RVALID, RRESP, RDATA};
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    error_d   = error_q;
    wr_busy_d = wr_busy_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = 1'b0;           // ready replies never stretch beyond one cycle
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
`ifdef AXI_LITE_STIM_READBACK_EN
    rd_busy_d = rd_busy_q;
    arvalid_d = arvalid_q;
    rready_d  = 1'b0;
    araddr_d  = araddr_q;
    rexp_d    = rexp_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d   = ST_WRITE;
          idx_d     = 5'd0;
          error_d   = 1'b0;
          wr_busy_d = 1'b0;
        end
      end

      ST_WRITE: begin
        if (!wr_busy_q) begin
          // Address and data launch together and stay frozen until accepted.
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = txn_addr;
          wdata_d   = txn_data;
          wr_busy_d = 1'b1;
        end else begin
          if (awvalid_q && AWREADY) awvalid_d = 1'b0;
          if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
          // Pulse BREADY once per response; the handshake completes on the
          // following edge while BVALID is still held by the slave.
          bready_d = BVALID & ~bready_q;
          if (b_hs) begin
            wr_busy_d = 1'b0;
            if (BRESP != 2'b00) error_d = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d = 5'd0;
`ifdef AXI_LITE_STIM_READBACK_EN
              state_d   = ST_READ;
              rd_busy_d = 1'b0;
`else
              state_d = ST_DONE;
`endif
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
        end
      end

      ST_READ: begin
`ifdef AXI_LITE_STIM_READBACK_EN
        if (!rd_busy_q) begin
          arvalid_d = 1'b1;
          araddr_d  = txn_addr;
          rexp_d    = txn_data;
          rd_busy_d = 1'b1;
        end else begin
          if (arvalid_q && ARREADY) arvalid_d = 1'b0;
          rready_d = RVALID & ~rready_q;
          if (r_hs) begin
            rd_busy_d = 1'b0;
            if ((RRESP != 2'b00) || (RDATA != rexp_q)) error_d = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d   = 5'd0;
              state_d = ST_DONE;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
        end
`else
        // Not reachable without read-back; fall through to completion.
        state_d = ST_DONE;
`endif
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge S_LITE_AXI_ACLK or posedge S_LITE_AXI_ARESETN) begin
    if (S_LITE_AXI_ARESETN) begin
      state_q    <= ST_IDLE;
      init_q     <= 1'b0;
      init_dly_q <= 1'b0;
      idx_q      <= 5'd0;
      error_q    <= 1'b0;
      wr_busy_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      awaddr_q   <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      init_q     <= INIT_AXI_TXN;
      init_dly_q <= init_q;
      idx_q      <= idx_d;
      error_q    <= error_d;
      wr_busy_q  <= wr_busy_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
    end
  end

`ifdef AXI_LITE_STIM_READBACK_EN
  always_ff @(posedge S_LITE_AXI_ACLK or posedge S_LITE_AXI_ARESETN) begin
    if (S_LITE_AXI_ARESETN) begin
      rd_busy_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= 32'd0;
      rexp_q    <= 32'd0;
    end else begin
      rd_busy_q <= rd_busy_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      araddr_q  <= araddr_d;
      rexp_q    <= rexp_d;
    end
  end

  assign ARADDR  = araddr_q;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;
`else
  assign ARADDR  = 32'd0;
  assign ARVALID = 1'b0;
  assign RREADY  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign AWADDR   = awaddr_q;
  assign AWPROT   = 3'b000;
  assign AWVALID  = awvalid_q;
  assign WDATA    = wdata_q;
  assign WSTRB    = 4'hF;
  assign WVALID   = wvalid_q;
  assign BREADY   = bready_q;
  assign ARPROT   = 3'b000;
  assign TXN_DONE = (state_q == ST_DONE);
  assign ERROR    = error_q;

endmodule

// File: tb/tb_virtual_axi_lite_stimulation.sv
// Bench for virtual_axi_lite_stimulation: a reactive AXI4-Lite slave with
// programmable ready delays and responses, plus a scoreboard of expected writes.
module tb_virtual_axi_lite_stimulation;

  localparam logic [1:0]  MODE  = 2'b01;
  localparam logic [31:0] START = 32'h8000_0000;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          N     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INIT_AXI_TXN = 1'b0;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY, TXN_DONE, ERROR;
  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
  logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;
  logic [31:0] RDATA = 32'd0;

  always #5 clk = ~clk;

  virtual_axi_lite_stimulation #(
    .PAILLIER_MODE(MODE),
    .C_M_START_DATA_VALUE(START),
    .C_M_TARGET_SLAVE_BASE_ADDR(BASE),
    .C_M_TRANSACTIONS_NUM(N)
  ) dut (
    .S_LITE_AXI_ACLK(clk), .S_LITE_AXI_ARESETN(rst), .INIT_AXI_TXN(INIT_AXI_TXN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .TXN_DONE(TXN_DONE), .ERROR(ERROR)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  wr_t e;
  logic [31:0] mem [0:15];

  // slave configuration
  int          aw_lat = 1, w_lat = 1;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] rcorrupt = 32'd0;

  // slave state
  int          aw_cnt = 0, w_cnt = 0;
  bit          aw_fire = 0, w_fire = 0, b_fire = 0, ar_fire = 0, r_fire = 0;
  bit          aw_got = 0, w_got = 0, ar_got = 0;
  logic [31:0] cap_addr = 0, cap_data = 0, ar_cap = 0;

  // monitors
  int   wr_cnt = 0, rd_cnt = 0, ar_seen = 0, aw_total = 0, w_total = 0, done_pulses = 0;
  int   aw_run = 0, w_run = 0, aw_run_err = 0, w_run_err = 0, stable_err = 0, prot_err = 0;
  int   bready_viol = 0, rready_viol = 0;
  logic bready_prev = 0, rready_prev = 0;
  logic [31:0] awaddr_prev = 0, wdata_prev = 0;

  initial for (int i = 0; i < 16; i++) mem[i] = 32'd0;

  // Slave and monitors act on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst) begin
      AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
      aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
      aw_got = 0; w_got = 0; ar_got = 0; aw_cnt = 0; w_cnt = 0;
      aw_run = 0; w_run = 0; bready_prev = 0; rready_prev = 0;
    end else begin
      if (AWVALID) begin
        if (aw_run > 0 && AWADDR !== awaddr_prev) stable_err++;
        aw_run++; aw_total++; awaddr_prev = AWADDR;
        if (AWPROT !== 3'b000) prot_err++;
      end
      if (WVALID) begin
        if (w_run > 0 && WDATA !== wdata_prev) stable_err++;
        w_run++; w_total++; wdata_prev = WDATA;
        if (WSTRB !== 4'hF) prot_err++;
      end
      if (ARVALID) begin
        ar_seen++;
        if (ARPROT !== 3'b000) prot_err++;
      end
      if (BREADY && bready_prev) bready_viol++;
      if (RREADY && rready_prev) rready_viol++;
      bready_prev = BREADY; rready_prev = RREADY;
      if (TXN_DONE) done_pulses++;

      // write response: issued one cycle after both address and data were taken
      if (b_fire) begin
        BVALID = 0; b_fire = 0;
      end else if (BVALID && BREADY) begin
        b_fire = 1;
      end else if (aw_got && w_got && !BVALID) begin
        aw_got = 0; w_got = 0; wr_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_write: unexpected write addr=%h data=%h", cap_addr, cap_data);
        end else begin
          e = exp_q.pop_front();
          if (cap_addr !== e.addr || cap_data !== e.data) begin
            miscompares++;
            $display("FAIL scoreboard_write: got addr=%h data=%h, want addr=%h data=%h",
                     cap_addr, cap_data, e.addr, e.data);
          end
        end
        mem[cap_addr[5:2]] = cap_data;
        BRESP = bresp_cfg; BVALID = 1;
      end

      // write address / data acceptance
      if (aw_fire) begin
        AWREADY = 0; aw_fire = 0; aw_cnt = 0;
      end else if (AWVALID && !AWREADY) begin
        aw_cnt++;
        if (aw_cnt >= aw_lat) AWREADY = 1;
      end
      if (AWVALID && AWREADY) begin
        aw_fire = 1; aw_got = 1; cap_addr = AWADDR;
        if (aw_run != aw_lat) aw_run_err++;
        aw_run = 0;
      end
      if (w_fire) begin
        WREADY = 0; w_fire = 0; w_cnt = 0;
      end else if (WVALID && !WREADY) begin
        w_cnt++;
        if (w_cnt >= w_lat) WREADY = 1;
      end
      if (WVALID && WREADY) begin
        w_fire = 1; w_got = 1; cap_data = WDATA;
        if (w_run != w_lat) w_run_err++;
        w_run = 0;
      end

      // read data, then read address
      if (r_fire) begin
        RVALID = 0; r_fire = 0;
      end else if (RVALID && RREADY) begin
        r_fire = 1;
      end else if (ar_got && !RVALID) begin
        ar_got = 0; rd_cnt++;
        RDATA = mem[ar_cap[5:2]] ^ rcorrupt; RRESP = 2'b00; RVALID = 1;
      end
      if (ar_fire) begin
        ARREADY = 0; ar_fire = 0;
      end else if (ARVALID && !ARREADY) begin
        ARREADY = 1;
      end
      if (ARVALID && ARREADY) begin
        ar_fire = 1; ar_got = 1; ar_cap = ARADDR;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // ---------------------------------------------------------------------------
  task automatic push_expected();
    wr_t x;
    for (int i = 0; i < N; i++) begin
      x.addr = BASE + 32'(4 * i);
      x.data = ((START + 32'(i)) & 32'hFFFF_FFFC) | {30'd0, MODE};
      exp_q.push_back(x);
    end
  endtask

  task automatic pulse_init();
    @(negedge clk); INIT_AXI_TXN = 1'b1;
    repeat (2) @(negedge clk);
    INIT_AXI_TXN = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out, output logic err, output int width);
    int t;
    t = 0; width = 0;
    while (TXN_DONE !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    timed_out = (TXN_DONE !== 1'b1);
    err = ERROR;
    while (TXN_DONE === 1'b1 && width < 10) begin width++; @(negedge clk); end
  endtask

  task automatic run_sequence(output bit to, output logic err, output int width, output int writes);
    int w0;
    push_expected();
    w0 = wr_cnt;
    pulse_init();
    wait_done(to, err, width);
    writes = wr_cnt - w0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, TXN_DONE, ERROR} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {AWVALID, WVALID, BREADY, ARVALID, RREADY, TXN_DONE, ERROR});
    end
    vectors++;
    if ({AWADDR, WDATA, ARADDR} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_payload: got aw=%h w=%h ar=%h want 0", AWADDR, WDATA, ARADDR);
    end
    vectors++;
    if ({AWPROT, ARPROT, WSTRB} !== {3'b000, 3'b000, 4'hF}) begin
      miscompares++;
      $display("FAIL reset_prot_strb: got %b want 0000001111", {AWPROT, ARPROT, WSTRB});
    end
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (aw_total !== 0 || ar_seen !== 0) begin
      miscompares++;
      $display("FAIL reset_idle: got aw=%0d ar=%0d valid cycles want 0", aw_total, ar_seen);
    end
  endtask

  task automatic test_basic_writes();
    bit to; logic err; int width, writes, ar0, r0;
    aw_lat = 1; w_lat = 1; bresp_cfg = 2'b00; rcorrupt = 0;
    ar0 = ar_seen; r0 = rd_cnt;
    run_sequence(to, err, width, writes);
    vectors++;
    if (to) begin miscompares++; $display("FAIL basic_timeout: TXN_DONE never seen"); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL basic_error: got %b want 0", err); end
    vectors++;
    if (width !== 1) begin miscompares++; $display("FAIL basic_done_width: got %0d want 1", width); end
    vectors++;
    if (writes !== N) begin miscompares++; $display("FAIL basic_writes: got %0d want %0d", writes, N); end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++; $display("FAIL basic_sb_left: got %0d want 0", exp_q.size()); exp_q.delete();
    end
    vectors++;
    if (aw_run_err !== 0 || w_run_err !== 0) begin
      miscompares++; $display("FAIL basic_valid_len: got aw=%0d w=%0d bad want 0", aw_run_err, w_run_err);
    end
    vectors++;
    if (bready_viol !== 0 || rready_viol !== 0 || prot_err !== 0) begin
      miscompares++;
      $display("FAIL basic_protocol: got bready=%0d rready=%0d prot=%0d want 0",
               bready_viol, rready_viol, prot_err);
    end
`ifdef AXI_LITE_STIM_READBACK_EN
    vectors++;
    if (rd_cnt - r0 !== N || ar_seen - ar0 !== N) begin
      miscompares++;
      $display("FAIL basic_reads: got %0d reads %0d ar cycles want %0d", rd_cnt - r0, ar_seen - ar0, N);
    end
`else
    vectors++;
    if (ar_seen - ar0 !== 0 || rd_cnt - r0 !== 0) begin
      miscompares++; $display("FAIL basic_no_reads: got %0d ar cycles want 0", ar_seen - ar0);
    end
`endif
  endtask

  task automatic test_aw_delay();
    bit to; logic err; int width, writes;
    aw_lat = 3; w_lat = 1; aw_run_err = 0; w_run_err = 0; stable_err = 0;
    run_sequence(to, err, width, writes);
    vectors++;
    if (to || err !== 1'b0) begin
      miscompares++; $display("FAIL awdelay_done: got timeout=%0d err=%b want 0/0", to, err);
    end
    vectors++;
    if (aw_run_err !== 0) begin
      miscompares++; $display("FAIL awdelay_aw_len: got %0d writes with AWVALID != 3 cycles want 0", aw_run_err);
    end
    vectors++;
    if (w_run_err !== 0) begin
      miscompares++; $display("FAIL awdelay_w_len: got %0d writes with WVALID != 1 cycle want 0", w_run_err);
    end
    vectors++;
    if (stable_err !== 0) begin
      miscompares++; $display("FAIL awdelay_stable: got %0d payload changes want 0", stable_err);
    end
    vectors++;
    if (writes !== N || bready_viol !== 0) begin
      miscompares++; $display("FAIL awdelay_bresp: got %0d B handshakes viol=%0d want %0d/0", writes, bready_viol, N);
    end
    if (exp_q.size() != 0) exp_q.delete();
    aw_lat = 1;
  endtask

  task automatic test_bresp_error();
    bit to; logic err; int width, writes;
    bresp_cfg = 2'b10;
    run_sequence(to, err, width, writes);
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL bresp_error: got %b want 1", err); end
    vectors++;
    if (to || width !== 1) begin
      miscompares++; $display("FAIL bresp_done: got timeout=%0d width=%0d want 0/1", to, width);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if (ERROR !== 1'b1) begin miscompares++; $display("FAIL bresp_sticky: got %b want 1", ERROR); end
    bresp_cfg = 2'b00;
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic test_restart_clears();
    bit to; logic err; int width;
    push_expected();
    pulse_init();
    vectors++;
    if (ERROR !== 1'b0) begin miscompares++; $display("FAIL restart_clear: got %b want 0", ERROR); end
    wait_done(to, err, width);
    vectors++;
    if (to || err !== 1'b0 || width !== 1) begin
      miscompares++;
      $display("FAIL restart_done: got timeout=%0d err=%b width=%0d want 0/0/1", to, err, width);
    end
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic test_rdata_corrupt();
    bit to; logic err; int width, writes;
    rcorrupt = 32'h0000_0100;
    run_sequence(to, err, width, writes);
`ifdef AXI_LITE_STIM_READBACK_EN
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL rdata_corrupt: got %b want 1", err); end
`else
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL rdata_ignored: got %b want 0", err); end
`endif
    vectors++;
    if (to || width !== 1) begin
      miscompares++; $display("FAIL rdata_done: got timeout=%0d width=%0d want 0/1", to, width);
    end
    rcorrupt = 32'd0;
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic test_init_ignored();
    bit to; logic err; int width, w0, t, d0, aw0;
    push_expected();
    w0 = wr_cnt; d0 = done_pulses; t = 0;
    pulse_init();
`ifdef AXI_LITE_STIM_READBACK_EN
    while (ARVALID !== 1'b1 && t < 500) begin @(negedge clk); t++; end
`else
    while (wr_cnt - w0 < 2 && t < 500) begin @(negedge clk); t++; end
`endif
    vectors++;
    if (t >= 500) begin miscompares++; $display("FAIL ignored_reach_phase: timeout after %0d cycles", t); end
    pulse_init();
    wait_done(to, err, width);
    aw0 = aw_total;
    repeat (30) @(negedge clk);
    vectors++;
    if (to || wr_cnt - w0 !== N) begin
      miscompares++; $display("FAIL ignored_writes: got %0d writes timeout=%0d want %0d/0", wr_cnt - w0, to, N);
    end
    vectors++;
    if (done_pulses - d0 !== 1 || aw_total !== aw0) begin
      miscompares++;
      $display("FAIL ignored_restart: got %0d done pulses, %0d later aw cycles want 1/0",
               done_pulses - d0, aw_total - aw0);
    end
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit to; logic err; int width, writes, t, aw0, w0c, ar0, wr0;
    push_expected();
    t = 0;
    pulse_init();
    while (AWVALID !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, TXN_DONE} !== 6'b0) begin
      miscompares++;
      $display("FAIL midreset_valids: got %b want 000000",
               {AWVALID, WVALID, BREADY, ARVALID, RREADY, TXN_DONE});
    end
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    aw0 = aw_total; w0c = w_total; ar0 = ar_seen; wr0 = wr_cnt;
    repeat (20) @(negedge clk);
    vectors++;
    if (aw_total !== aw0 || w_total !== w0c || ar_seen !== ar0 || wr_cnt !== wr0) begin
      miscompares++;
      $display("FAIL midreset_quiet: got aw=%0d w=%0d ar=%0d b=%0d new cycles want 0",
               aw_total - aw0, w_total - w0c, ar_seen - ar0, wr_cnt - wr0);
    end
    run_sequence(to, err, width, writes);
    vectors++;
    if (to || err !== 1'b0 || writes !== N) begin
      miscompares++;
      $display("FAIL midreset_recover: got timeout=%0d err=%b writes=%0d want 0/0/%0d", to, err, writes, N);
    end
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic_writes();
    test_aw_delay();
    test_bresp_error();
    test_restart_clears();
    test_rdata_corrupt();
    test_init_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
